// File: rtl/matmul_sequencer.sv
// Purpose : sequences C[i][j] = sum_k A[i][k]*B[k][j] over row-major A/B buffers into a MAC.
// Latency : K+3 cycles per result (CLEAR, K x ISSUE, DRAIN, OUTPUT) with c_ready held high.
// Backpr. : c_ready low holds OUTPUT (c_valid/c_addr/c_data stable); no reads while stalled.
//
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start, dim_m/n/k             job request and matrix dimensions (latched on accepted start)
//   busy, done                   job in progress, one-cycle end-of-job pulse
//   a_rd_en/a_addr/a_rdata       A buffer sync read port (data one cycle after strobe)
//   b_rd_en/b_addr/b_rdata       B buffer sync read port (same strobe as A)
//   mac_clear/enable/a/b/accum   MAC control, operands and accumulator return
//   c_valid/c_ready/c_addr/c_data result write-back handshake
module matmul_sequencer #(
    parameter int DATA_W = 32,
    parameter int DIM_W  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [DIM_W-1:0]  dim_k,
    output logic              busy,
    output logic              done,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_rdata,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_rdata,
    output logic              mac_clear,
    output logic              mac_enable,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b,
    input  logic [DATA_W-1:0] mac_accum,
    output logic              c_valid,
    input  logic              c_ready,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_data
);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_OUTPUT, S_FINISH
    } state_t;

    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    state_t           state_q, state_d;
    logic [DIM_W-1:0] m_q, m_d, n_q, n_d, kd_q, kd_d;
    logic [DIM_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic             en_q;

    logic last_k, last_j, last_i;
    assign last_k = (k_q == kd_q - DIM_ONE);
    assign last_j = (j_q == n_q - DIM_ONE);
    assign last_i = (i_q == m_q - DIM_ONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Dimension latches, loop counters and the read-to-enable alignment stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q  <= '0;
            n_q  <= '0;
            kd_q <= '0;
            i_q  <= '0;
            j_q  <= '0;
            k_q  <= '0;
            en_q <= 1'b0;
        end else begin
            m_q  <= m_d;
            n_q  <= n_d;
            kd_q <= kd_d;
            i_q  <= i_d;
            j_q  <= j_d;
            k_q  <= k_d;
            // read data arrives one cycle after the strobe, so enable follows it
            en_q <= (state_q == S_ISSUE);
        end
    end

    // Next-state and counter update
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        n_d     = n_q;
        kd_d    = kd_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d  = dim_m;
                    n_d  = dim_n;
                    kd_d = dim_k;
                    i_d  = '0;
                    j_d  = '0;
                    if (dim_m == '0 || dim_n == '0 || dim_k == '0) begin
                        state_d = S_FINISH;
                    end else begin
                        state_d = S_CLEAR;
                    end
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                k_d = k_q + DIM_ONE;
                if (last_k) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                if (c_ready) begin
                    if (last_i && last_j) begin
                        i_d     = '0;
                        j_d     = '0;
                        state_d = S_FINISH;
                    end else begin
                        if (last_j) begin
                            j_d = '0;
                            i_d = i_q + DIM_ONE;
                        end else begin
                            j_d = j_q + DIM_ONE;
                        end
                        state_d = S_CLEAR;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy      = (state_q != S_IDLE);
        done      = (state_q == S_FINISH);
        a_rd_en   = (state_q == S_ISSUE);
        mac_clear = (state_q == S_CLEAR);
        c_valid   = (state_q == S_OUTPUT);
    end

    assign b_rd_en    = a_rd_en;
    assign mac_enable = en_q;
    assign mac_a      = a_rdata;
    assign mac_b      = b_rdata;
    assign c_data     = mac_accum;

    // Address arithmetic is carried out at ADDR_W and wraps
    assign a_addr = ADDR_W'(i_q) * ADDR_W'(kd_q) + ADDR_W'(k_q);
    assign b_addr = ADDR_W'(k_q) * ADDR_W'(n_q) + ADDR_W'(j_q);
    assign c_addr = ADDR_W'(i_q) * ADDR_W'(n_q) + ADDR_W'(j_q);

endmodule

// File: tb/tb_matmul_sequencer.sv
module tb_matmul_sequencer;

    localparam int DATA_W = 32;
    localparam int DIM_W  = 4;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              start = 1'b0;
    logic [DIM_W-1:0]  dim_m = '0, dim_n = '0, dim_k = '0;
    logic              busy, done;
    logic              a_rd_en, b_rd_en;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
    logic [DATA_W-1:0] a_rdata, b_rdata;
    logic              mac_clear, mac_enable;
    logic [DATA_W-1:0] mac_a, mac_b, mac_accum, c_data;
    logic              c_valid;
    logic              c_ready = 1'b1;

    matmul_sequencer #(.DATA_W(DATA_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .dim_m(dim_m), .dim_n(dim_n), .dim_k(dim_k),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rdata(a_rdata),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rdata(b_rdata),
        .mac_clear(mac_clear), .mac_enable(mac_enable),
        .mac_a(mac_a), .mac_b(mac_b), .mac_accum(mac_accum),
        .c_valid(c_valid), .c_ready(c_ready), .c_addr(c_addr), .c_data(c_data)
    );

    always #5 clk = ~clk;

    // Operand buffers: synchronous read, one cycle latency
    logic [DATA_W-1:0] a_mem [256];
    logic [DATA_W-1:0] b_mem [256];
    always @(posedge clk) begin
        if (a_rd_en) a_rdata <= a_mem[a_addr];
        if (b_rd_en) b_rdata <= b_mem[b_addr];
    end

    // Downstream multiply-accumulate unit
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n)        mac_accum <= '0;
        else if (mac_clear)  mac_accum <= '0;
        else if (mac_enable) mac_accum <= mac_accum + mac_a * mac_b;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference results in emission order
    logic [ADDR_W-1:0] exp_addr [$];
    logic [DATA_W-1:0] exp_data [$];

    task automatic build_expected(input int m, input int n, input int k);
        logic [DATA_W-1:0] sum;
        exp_addr.delete();
        exp_data.delete();
        if (m * n * k != 0) begin
            for (int i = 0; i < m; i++) begin
                for (int j = 0; j < n; j++) begin
                    sum = '0;
                    for (int kk = 0; kk < k; kk++) sum += a_mem[i*k+kk] * b_mem[kk*n+j];
                    exp_addr.push_back(ADDR_W'(i*n + j));
                    exp_data.push_back(sum);
                end
            end
        end
    endtask

    task automatic fill_random(input int m, input int n, input int k);
        for (int x = 0; x < m*k; x++) a_mem[x] = $urandom;
        for (int x = 0; x < k*n; x++) b_mem[x] = $urandom;
    endtask

    // Runs one job from the start pulse to one cycle past done; all sampling on negedge.
    task automatic run_job(input string name, input int m, input int n, input int k,
                           input int stall_first, input bit rand_ready, input bit poke_start);
        int cyc, last_hs, nres, nreads, rd_mismatch, exp_res;
        bit expect_new, seen_done;
        build_expected(m, n, k);
        exp_res = (m * n * k == 0) ? 0 : m * n;
        dim_m = DIM_W'(m); dim_n = DIM_W'(n); dim_k = DIM_W'(k);
        c_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; last_hs = 0; nres = 0; nreads = 0; rd_mismatch = 0;
        expect_new = 1'b1; seen_done = 1'b0;
        chk({name, " busy after start"}, busy, 1);
        while (!seen_done && cyc < 3000) begin
            if (poke_start && cyc == 2) begin
                start = 1'b1; dim_m = 4'd3; dim_n = 4'd3; dim_k = 4'd3;
            end else begin
                start = 1'b0;
            end
            if (a_rd_en) nreads++;
            if (b_rd_en !== a_rd_en) rd_mismatch++;
            if (done) begin
                seen_done = 1'b1;
                chk({name, " done cycle"}, cyc, (exp_res == 0) ? 1 : last_hs + 1);
                chk({name, " result count"}, nres, exp_res);
                chk({name, " read count"}, nreads, exp_res * k);
            end else if (c_valid) begin
                if (expect_new) begin
                    chk({name, " result latency"}, cyc, last_hs + k + 3);
                    expect_new = 1'b0;
                end
                chk({name, " no reads in output"}, a_rd_en, 0);
                chk({name, " mac idle in output"}, {mac_clear, mac_enable}, 0);
                chk({name, " result expected"}, (exp_addr.size() > 0), 1);
                if (exp_addr.size() > 0) begin
                    chk({name, " c_addr"}, c_addr, exp_addr[0]);
                    chk({name, " c_data"}, c_data, exp_data[0]);
                    if (nres == 0 && stall_first > 0) begin
                        c_ready = 1'b0;
                        stall_first--;
                    end else if (rand_ready && $urandom_range(0, 2) == 0) begin
                        c_ready = 1'b0;
                    end else begin
                        c_ready = 1'b1;
                        void'(exp_addr.pop_front());
                        void'(exp_data.pop_front());
                        nres++;
                        last_hs = cyc;
                        expect_new = 1'b1;
                    end
                end
            end else begin
                c_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk({name, " finished in budget"}, seen_done, 1);
        chk({name, " b_rd_en tracks a_rd_en"}, rd_mismatch, 0);
        start = 1'b0;
        c_ready = 1'b1;
        chk({name, " idle after done"}, {busy, done}, 0);
    endtask

    initial begin
        int w;
        // Reset state
        #2 reset_n = 1'b0;
        #1;
        chk("reset ctrl outputs", {busy, done, a_rd_en, b_rd_en, mac_clear, mac_enable, c_valid}, 0);
        chk("reset addresses", {a_addr, b_addr, c_addr}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle after reset", {busy, done, c_valid}, 0);

        // 1x1x1
        a_mem[0] = 32'd3; b_mem[0] = 32'd4;
        run_job("t1", 1, 1, 1, 0, 1'b0, 1'b0);

        // 2x2x2 directed
        a_mem[0] = 1; a_mem[1] = 2; a_mem[2] = 3; a_mem[3] = 4;
        b_mem[0] = 5; b_mem[1] = 6; b_mem[2] = 7; b_mem[3] = 8;
        run_job("t2", 2, 2, 2, 0, 1'b0, 1'b0);

        // 2x2x2 with 5-cycle stall on the first result
        run_job("t3", 2, 2, 2, 5, 1'b0, 1'b0);

        // Zero dimensions
        run_job("t4k0", 2, 2, 0, 0, 1'b0, 1'b0);
        run_job("t4m0", 0, 3, 2, 0, 1'b0, 1'b0);

        // Reset during ISSUE, then an identical job
        dim_m = 4'd2; dim_n = 4'd2; dim_k = 4'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        w = 0;
        while (!(a_rd_en && a_addr == 8'd1) && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("t5 reached second issue", a_addr, 1);
        reset_n = 1'b0;
        #1;
        chk("t5 ctrl cleared", {busy, done, a_rd_en, b_rd_en, mac_clear, mac_enable, c_valid}, 0);
        chk("t5 addresses cleared", {a_addr, b_addr, c_addr}, 0);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk("t5 quiet in reset", {a_rd_en, c_valid, done}, 0);
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("t5 idle after release", {busy, c_valid, a_rd_en}, 0);
        run_job("t5 rerun", 2, 2, 2, 0, 1'b0, 1'b0);

        // start while busy is ignored
        run_job("t6", 2, 2, 2, 0, 1'b0, 1'b1);

        // Randomized jobs with random backpressure
        for (int t = 0; t < 6; t++) begin
            int m, n, k;
            m = $urandom_range(1, 4);
            n = $urandom_range(1, 4);
            k = $urandom_range(1, 4);
            fill_random(m, n, k);
            run_job($sformatf("rand%0d", t), m, n, k, $urandom_range(0, 3), 1'b1, 1'(t & 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
